// File: rtl/fp_mult_pkg.sv
// Shared definitions for the significand multiplier.
//   MANT_W : significand width including the hidden bit
//   PROD_W : raw product width
//   FRAC_W : stored fraction width (hidden bit dropped)
//   state_t: sequencer states of the shift-add multiplier
package fp_mult_pkg;

  localparam int MANT_W = 24;
  localparam int PROD_W = 2 * MANT_W;
  localparam int FRAC_W = MANT_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_mant.sv
// Sequential shift-add significand multiplier with normalization taps.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : request a multiply (taken in IDLE or DONE)
//   aMant, bMant      : multiplicand / multiplier, hidden bit at MSB
//   busy              : operation in progress (RUN)
//   done              : one-cycle pulse, results valid from this cycle
//   product           : raw unsigned 2*MANT_W-bit product
//   normCarry         : product MSB, feeds the exponent adder carry-in
//   fracOut           : normalized fraction without hidden bit
//   guard, sticky     : rounding bits below fracOut
module mult_mant
  import fp_mult_pkg::*;
#(
  parameter int MANT_W = fp_mult_pkg::MANT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MANT_W-1:0]     aMant,
  input  logic [MANT_W-1:0]     bMant,
  output logic                  busy,
  output logic                  done,
  output logic [2*MANT_W-1:0]   product,
  output logic                  normCarry,
  output logic [MANT_W-2:0]     fracOut,
  output logic                  guard,
  output logic                  sticky
);

  localparam int P     = 2 * MANT_W;
  localparam int CNT_W = $clog2(MANT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W);

  state_t            state, state_nxt;
  logic              accept, finish;
  logic [MANT_W-1:0] mcand, mplier;
  logic [P-1:0]      acc;
  logic [CNT_W-1:0]  cnt;
  logic [MANT_W:0]   sum;

  logic              nc_c, guard_c, sticky_c;
  logic [MANT_W-2:0] frac_c;

  // Sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // RUN holds MANT_W shift-add steps (cnt 0..MANT_W-1) plus one final cycle
  // at cnt==MANT_W that hands the finished accumulator to the result regs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Upper half plus the selected multiplicand, carry kept in bit MANT_W
  assign sum = {1'b0, acc[P-1:MANT_W]} + (mplier[0] ? {1'b0, mcand} : '0);

  // Datapath: operands latched on acceptance, so input changes mid-run
  // have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= aMant;
      mplier <= bMant;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN && !finish) begin
      acc    <= {sum, acc[MANT_W-1:1]};
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Normalization taps on the finished accumulator
  always_comb begin
    nc_c = acc[P-1];
    if (nc_c) begin
      frac_c   = acc[P-2:MANT_W];
      guard_c  = acc[MANT_W-1];
      sticky_c = |acc[MANT_W-2:0];
    end else begin
      frac_c   = acc[P-3:MANT_W-1];
      guard_c  = acc[MANT_W-2];
      sticky_c = |acc[MANT_W-3:0];
    end
  end

  // Results load only on RUN->DONE and hold until the next completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product   <= '0;
      normCarry <= 1'b0;
      fracOut   <= '0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
    end else if (finish) begin
      product   <= acc;
      normCarry <= nc_c;
      fracOut   <= frac_c;
      guard     <= guard_c;
      sticky    <= sticky_c;
    end
  end

endmodule

// File: tb/tb_mult_mant.sv
// Self-checking bench for mult_mant: directed steps, scoreboard of expected
// results popped when done pulses, latency checked against the accept edge.
module tb_mult_mant;

  localparam int M   = 24;
  localparam int P   = 48;
  localparam int LAT = 25;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] aMant = '0;
  logic [M-1:0] bMant = '0;
  logic         busy, done;
  logic [P-1:0] product;
  logic         normCarry;
  logic [M-2:0] fracOut;
  logic         guard, sticky;

  mult_mant #(.MANT_W(M)) dut (
    .clk(clk), .rst(rst), .start(start), .aMant(aMant), .bMant(bMant),
    .busy(busy), .done(done), .product(product), .normCarry(normCarry),
    .fracOut(fracOut), .guard(guard), .sticky(sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [P-1:0] prod;
    logic         nc;
    logic [M-2:0] frac;
    logic         g;
    logic         s;
    int           due;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0, dones = 0, exp_dones = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b, input int due);
    exp_t e;
    logic [P-1:0] p;
    p = {{M{1'b0}}, a} * {{M{1'b0}}, b};
    e.prod = p;
    e.nc   = p[P-1];
    if (p[P-1]) begin
      e.frac = p[P-2:M];
      e.g    = p[M-1];
      e.s    = |p[M-2:0];
    end else begin
      e.frac = p[P-3:M-1];
      e.g    = p[M-2];
      e.s    = |p[M-3:0];
    end
    e.due = due;
    return e;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      dones++;
      chk("busy_low_in_done", 64'(busy), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("product",   64'(product),   64'(e.prod));
        chk("normCarry", 64'(normCarry), 64'(e.nc));
        chk("fracOut",   64'(fracOut),   64'(e.frac));
        chk("guard",     64'(guard),     64'(e.g));
        chk("sticky",    64'(sticky),    64'(e.s));
        chk("latency",   64'(cyc),       64'(e.due));
      end
    end
  end

  // Drive one start pulse; accept edge is the next posedge (cyc+1)
  task automatic issue(input logic [M-1:0] a, input logic [M-1:0] b, input bit push);
    @(negedge clk);
    start = 1'b1;
    aMant = a;
    bMant = b;
    if (push) begin
      sb.push_back(model(a, b, cyc + 1 + LAT));
      exp_dones++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},    64'(busy),      64'd0);
    chk({tag, "_done"},    64'(done),      64'd0);
    chk({tag, "_product"}, 64'(product),   64'd0);
    chk({tag, "_nc"},      64'(normCarry), 64'd0);
    chk({tag, "_frac"},    64'(fracOut),   64'd0);
    chk({tag, "_guard"},   64'(guard),     64'd0);
    chk({tag, "_sticky"},  64'(sticky),    64'd0);
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Basic products: 1.0*1.0, 1.5*1.5, max*max
    issue(24'h800000, 24'h800000, 1'b1);
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_done(40);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);

    issue(24'hC00000, 24'hC00000, 1'b1);
    wait_done(40);
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b1);
    wait_done(40);
    issue(24'h123456, 24'hABCDEF, 1'b1);
    wait_done(40);
    // Zero operand is not special-cased
    issue(24'h000000, 24'hFFFFFF, 1'b1);
    wait_done(40);

    // Start mid-RUN ignored; operand changes after acceptance ignored
    issue(24'hA5A5A5, 24'h9C3F01, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    aMant = 24'hFFFFFF;
    bMant = 24'h800001;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    repeat (3) @(negedge clk);

    // Reset mid-RUN: everything clears asynchronously, no done
    issue(24'hDEADBE, 24'hBEEF01, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    issue(24'h800000, 24'hC00000, 1'b1);
    wait_done(40);

    // Back-to-back: start held through DONE with a second operand pair
    issue(24'hE00001, 24'h8F0F0F, 1'b1);
    wait_done(40);
    start = 1'b1;
    aMant = 24'hB504F3;
    bMant = 24'hB504F3;
    sb.push_back(model(aMant, bMant, cyc + 1 + LAT));
    exp_dones++;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(40);

    repeat (5) @(negedge clk);
    chk("sb_empty",   64'(sb.size()), 64'd0);
    chk("done_count", 64'(dones),     64'(exp_dones));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
